light_ct_serializer: RTL

//  Downstream stage of the light encryptor. Captures one {ciphertext, HMAC} record per handshake
//  and streams it out as fixed-width beats toward the CL write path, last beat flagged.

---
 rtl/light_ct_serializer.sv | 61 ++++++
 1 files changed

// File: rtl/light_ct_serializer.sv
// light_ct_serializer: captures one {hmac, ciphertext} record per handshake and streams it out LSB-first as fixed-width beats.
module light_ct_serializer #(
  parameter int CT_WIDTH  = 640,
  parameter int OUT_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CT_WIDTH-1:0]  in_ciphertext,
  input  logic [127:0]         in_hmac,
  input  logic                 in_val,
  output logic                 in_rdy,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [31:0]          rec_count
);
  localparam int REC_W = CT_WIDTH + 128;
  localparam int NUM_BEATS = REC_W / OUT_WIDTH;
  localparam int IDX_W = NUM_BEATS > 1 ? $clog2(NUM_BEATS) : 1;
  localparam logic [IDX_W-1:0] PEN_IDX = IDX_W'(NUM_BEATS > 1 ? NUM_BEATS - 2 : 0);
  typedef enum logic {IDLE, SEND} state_t;
  state_t            state;
  logic [IDX_W-1:0]  beat_idx;
  logic [REC_W-1:0]  rec;
  logic              take;
  logic              done;
  if (REC_W % OUT_WIDTH != 0) begin : g_bad_width
    $error("light_ct_serializer: CT_WIDTH+128 must be a multiple of OUT_WIDTH");
  end
  // Record is shifted down each beat so the current beat always sits in the low slice.
  assign out_data = rec[OUT_WIDTH-1:0];
  assign out_val  = state == SEND;
  assign done     = out_val && out_rdy && out_last;
  assign in_rdy   = state == IDLE || done;
  assign take     = in_val && in_rdy;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat_idx  <= '0;
      rec       <= '0;
      rec_count <= '0;
      out_last  <= 1'b0;
    end else begin
      if (done) rec_count <= rec_count + 32'd1;
      if (take) begin
        state    <= SEND;
        rec      <= {in_hmac, in_ciphertext};
        beat_idx <= '0;
        out_last <= NUM_BEATS == 1;
      end else if (done) begin
        state    <= IDLE;
        out_last <= 1'b0;
      end else if (out_val && out_rdy) begin
        rec      <= rec >> OUT_WIDTH;
        beat_idx <= beat_idx + 1'b1;
        out_last <= beat_idx == PEN_IDX;
      end
    end
  end
endmodule
